mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM that sequences fetch/decode/execute/memory/writeback
//  and drives the datapath selects and enables (regfile we3, flopen enables, mux2/mux3/mux4 selects,
//  byte-load extension select). Sits directly upstream of the datapath; consumes op from the
//  instruction register, zero from the ALU and a memory-ready handshake.
// PARAMETERS
//  none (all encodings are fixed in mc_ctrl_pkg)
// PORTS
//  clk          in   1  clock, all state changes on rising edge
//  reset        in   1  synchronous, active-high; one clock; reset is synchronous and active-high
//  op           in   6  instr[31:26], stable from the cycle after FETCH completes
//  zero         in   1  ALU zero flag
//  memready     in   1  memory has completed the current read/write this cycle
//  iord         out  1  address mux: 0=PC, 1=ALUOut
//  irwrite      out  1  instruction register enable
//  pcen         out  1  PC enable = pcwrite | (branch & zero)
//  memwrite     out  1  data memory write strobe
//  regwrite     out  1  regfile we3
//  regdst       out  1  write addr: 0=rt, 1=rd
//  wbsel        out  2  writeback mux3: 00=ALUOut, 01=mem data, 10={imm,16'b0} (LUI)
//  alusrca      out  1  0=PC, 1=regA
//  alusrcb      out  2  mux4: 00=regB, 01=4, 10=signimm, 11=signimm<<2
//  aluop        out  2  00=add, 01=sub, 10=use funct
//  pcsrc        out  2  00=ALU result, 01=ALUOut, 10=jump target
//  ldbyte       out  1  load data is an extended byte (LB/LBU)
//  ldunsigned   out  1  byte extension: 0=sign (LB), 1=zero (LBU)
//  badop        out  1  one-cycle pulse: unrecognised opcode seen in DECODE
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, LUIWB.
//  Reset: state<=FETCH on the clock edge with reset high; while reset is high irwrite, pcen, memwrite,
//   regwrite, badop are forced 0; all other outputs take their FETCH values. Reset mid-instruction abandons it.
//  Outputs are functions of state (and op/zero/memready where stated); default every output 0.
//  FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=memready; stay until memready.
//  DECODE: alusrca=0, alusrcb=11, aluop=00. Next by op: 100011 LW/101011 SW/100000 LB/100100 LBU->MEMADR,
//   000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, 001111->LUIWB; else badop=1, ->FETCH.
//  MEMADR: alusrca=1, alusrcb=10, aluop=00; ->MEMWR if op=SW else ->MEMRD.
//  MEMRD: iord=1; hold until memready, then ->MEMWB. MEMWR: iord=1, memwrite=1; hold until memready ->FETCH.
//  MEMWB: regdst=0, wbsel=01, regwrite=1; ldbyte=(op==LB|LBU), ldunsigned=(op==LBU); ->FETCH.
//  RTYPEEX: alusrca=1, alusrcb=00, aluop=10 ->RTYPEWB. RTYPEWB: regdst=1, wbsel=00, regwrite=1 ->FETCH.
//  BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 (pcen=zero) ->FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, aluop=00 ->ADDIWB. ADDIWB: regdst=0, wbsel=00, regwrite=1 ->FETCH.
//  JEX: pcsrc=10, pcwrite=1 ->FETCH. LUIWB: regdst=0, wbsel=10, regwrite=1 ->FETCH.
//  Latency (memready tied 1): R/ADDI 4 cycles, LW/LB/LBU 5, SW 4, BEQ/J/LUI 3; each memready=0 cycle adds 1.
//  memwrite and irwrite never assert in the same cycle; at most one of pcwrite/branch per state.
//  Unreachable state encodings -> FETCH next cycle, all enables 0.
// STRUCTURE
//  mc_ctrl_pkg: state enum (4-bit), opcode localparams, encodings for alusrcb, pcsrc, aluop, wbsel.
//  Single module: state register + always_comb next-state + always_comb output decode.
//  Funct decode stays in the separate mc_aludec (not instantiated here).
// TESTING
//  reset 2 cycles, memready=1 -> FETCH, irwrite=pcen=0 during reset, irwrite=pcen=1 first cycle after.
//  op=100011, memready low 2 cycles in MEMRD -> states F,D,MA,MR,MR,MR,MWB; regwrite=1 only in MWB, wbsel=01.
//  op=100100 -> MEMWB with ldbyte=1, ldunsigned=1; op=100000 -> ldbyte=1, ldunsigned=0.
//  op=000100, zero=1 -> pcen=1 in BEQEX with pcsrc=01; zero=0 -> pcen=0; both return to FETCH.
//  op=111111 -> badop=1 for exactly one cycle in DECODE, no write enable asserted, back to FETCH.
//  reset asserted in MEMWR with memready=0 -> memwrite=0 during reset, next state FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS main controller
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_LUIWB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_LUI    = 2'b10;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic is_byte_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LBU);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - Moore main controller sequencing the multicycle MIPS datapath
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       memready,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic [1:0] wbsel,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       ldbyte,
   output logic       ldunsigned,
   output logic       badop
);

   state_t state;
   state_t next_state;
   state_t dec_state;
   logic   pcwrite;
   logic   branch;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:   next_state = memready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_mem_op(op))        next_state = S_MEMADR;
            else if (op == OP_RTYPE)  next_state = S_RTYPEEX;
            else if (op == OP_BEQ)    next_state = S_BEQEX;
            else if (op == OP_ADDI)   next_state = S_ADDIEX;
            else if (op == OP_J)      next_state = S_JEX;
            else if (op == OP_LUI)    next_state = S_LUIWB;
            else                      next_state = S_FETCH;
         end
         S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   next_state = memready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next_state = memready ? S_FETCH : S_MEMWR;
         S_MEMWB:   next_state = S_FETCH;
         S_RTYPEEX: next_state = S_RTYPEWB;
         S_RTYPEWB: next_state = S_FETCH;
         S_BEQEX:   next_state = S_FETCH;
         S_ADDIEX:  next_state = S_ADDIWB;
         S_ADDIWB:  next_state = S_FETCH;
         S_JEX:     next_state = S_FETCH;
         S_LUIWB:   next_state = S_FETCH;
         default:   next_state = S_FETCH;
      endcase
   end

   // During reset the selects already show FETCH so the datapath settles before release.
   assign dec_state = reset ? S_FETCH : state;

   always_comb begin
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      wbsel      = WB_ALUOUT;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REGB;
      aluop      = ALUOP_ADD;
      pcsrc      = PCSRC_ALU;
      ldbyte     = 1'b0;
      ldunsigned = 1'b0;
      badop      = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (dec_state)
         S_FETCH: begin
            alusrcb = SRCB_FOUR;
            irwrite = memready;
            pcwrite = memready;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMM_SH2;
            badop   = ~(is_mem_op(op) || op == OP_RTYPE || op == OP_BEQ ||
                        op == OP_ADDI || op == OP_J || op == OP_LUI);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_MEMWB: begin
            wbsel      = WB_MEM;
            regwrite   = 1'b1;
            ldbyte     = is_byte_load(op);
            ldunsigned = (op == OP_LBU);
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         S_LUIWB: begin
            wbsel    = WB_LUI;
            regwrite = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         badop    = 1'b0;
         pcwrite  = 1'b0;
         branch   = 1'b0;
      end
   end

   assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for the multicycle main controller
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b0;
   logic       zero = 1'b0;
   logic       memready = 1'b1;
   logic       iord, irwrite, pcen, memwrite, regwrite, regdst, alusrca;
   logic       ldbyte, ldunsigned, badop;
   logic [1:0] wbsel, alusrcb, aluop, pcsrc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [17:0] exp;
   } item_t;
   item_t sb[$];

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
      .iord(iord), .irwrite(irwrite), .pcen(pcen), .memwrite(memwrite),
      .regwrite(regwrite), .regdst(regdst), .wbsel(wbsel), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .ldbyte(ldbyte),
      .ldunsigned(ldunsigned), .badop(badop)
   );

   // {iord,irwrite,pcen,memwrite,regwrite,regdst,wbsel,alusrca,alusrcb,aluop,pcsrc,ldbyte,ldunsigned,badop}
   localparam logic [17:0] E_RST     = 18'b0_0_0_0_0_0_00_0_01_00_00_0_0_0;
   localparam logic [17:0] E_FETCH1  = 18'b0_1_1_0_0_0_00_0_01_00_00_0_0_0;
   localparam logic [17:0] E_FETCH0  = 18'b0_0_0_0_0_0_00_0_01_00_00_0_0_0;
   localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_00_0_11_00_00_0_0_0;
   localparam logic [17:0] E_BAD     = 18'b0_0_0_0_0_0_00_0_11_00_00_0_0_1;
   localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_00_1_10_00_00_0_0_0;
   localparam logic [17:0] E_MEMRD   = 18'b1_0_0_0_0_0_00_0_00_00_00_0_0_0;
   localparam logic [17:0] E_MEMWR   = 18'b1_0_0_1_0_0_00_0_00_00_00_0_0_0;
   localparam logic [17:0] E_WB_LW   = 18'b0_0_0_0_1_0_01_0_00_00_00_0_0_0;
   localparam logic [17:0] E_WB_LB   = 18'b0_0_0_0_1_0_01_0_00_00_00_1_0_0;
   localparam logic [17:0] E_WB_LBU  = 18'b0_0_0_0_1_0_01_0_00_00_00_1_1_0;
   localparam logic [17:0] E_RTEX    = 18'b0_0_0_0_0_0_00_1_00_10_00_0_0_0;
   localparam logic [17:0] E_RTWB    = 18'b0_0_0_0_1_1_00_0_00_00_00_0_0_0;
   localparam logic [17:0] E_BEQ_T   = 18'b0_0_1_0_0_0_00_1_00_01_01_0_0_0;
   localparam logic [17:0] E_BEQ_N   = 18'b0_0_0_0_0_0_00_1_00_01_01_0_0_0;
   localparam logic [17:0] E_ADDIEX  = 18'b0_0_0_0_0_0_00_1_10_00_00_0_0_0;
   localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_1_0_00_0_00_00_00_0_0_0;
   localparam logic [17:0] E_JEX     = 18'b0_0_1_0_0_0_00_0_00_00_10_0_0_0;
   localparam logic [17:0] E_LUIWB   = 18'b0_0_0_0_1_0_10_0_00_00_00_0_0_0;

   task automatic cyc(input string name, input logic r, input logic [5:0] o,
                      input logic z, input logic mr, input logic [17:0] e);
      item_t it;
      @(posedge clk);
      #1;
      reset    = r;
      op       = o;
      zero     = z;
      memready = mr;
      it.name  = name;
      it.exp   = e;
      sb.push_back(it);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         item_t it;
         logic [17:0] act;
         it  = sb.pop_front();
         act = {iord, irwrite, pcen, memwrite, regwrite, regdst, wbsel, alusrca,
                alusrcb, aluop, pcsrc, ldbyte, ldunsigned, badop};
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
         end
      end
   end

   initial begin
      cyc("rst0", 1, 6'b000000, 0, 1, E_RST);
      cyc("rst1", 1, 6'b000000, 0, 1, E_RST);

      cyc("lw_f",    0, 6'b100011, 0, 1, E_FETCH1);
      cyc("lw_d",    0, 6'b100011, 0, 1, E_DECODE);
      cyc("lw_ma",   0, 6'b100011, 0, 1, E_MEMADR);
      cyc("lw_mr0",  0, 6'b100011, 0, 0, E_MEMRD);
      cyc("lw_mr1",  0, 6'b100011, 0, 0, E_MEMRD);
      cyc("lw_mr2",  0, 6'b100011, 0, 1, E_MEMRD);
      cyc("lw_wb",   0, 6'b100011, 0, 1, E_WB_LW);

      cyc("lbu_f",   0, 6'b100100, 0, 1, E_FETCH1);
      cyc("lbu_d",   0, 6'b100100, 0, 1, E_DECODE);
      cyc("lbu_ma",  0, 6'b100100, 0, 1, E_MEMADR);
      cyc("lbu_mr",  0, 6'b100100, 0, 1, E_MEMRD);
      cyc("lbu_wb",  0, 6'b100100, 0, 1, E_WB_LBU);

      cyc("lb_f",    0, 6'b100000, 0, 1, E_FETCH1);
      cyc("lb_d",    0, 6'b100000, 0, 1, E_DECODE);
      cyc("lb_ma",   0, 6'b100000, 0, 1, E_MEMADR);
      cyc("lb_mr",   0, 6'b100000, 0, 1, E_MEMRD);
      cyc("lb_wb",   0, 6'b100000, 0, 1, E_WB_LB);

      cyc("beqt_f",  0, 6'b000100, 1, 1, E_FETCH1);
      cyc("beqt_d",  0, 6'b000100, 1, 1, E_DECODE);
      cyc("beqt_x",  0, 6'b000100, 1, 1, E_BEQ_T);
      cyc("beqn_f",  0, 6'b000100, 0, 1, E_FETCH1);
      cyc("beqn_d",  0, 6'b000100, 0, 1, E_DECODE);
      cyc("beqn_x",  0, 6'b000100, 0, 1, E_BEQ_N);

      cyc("rt_stall",0, 6'b000000, 0, 0, E_FETCH0);
      cyc("rt_f",    0, 6'b000000, 0, 1, E_FETCH1);
      cyc("rt_d",    0, 6'b000000, 0, 1, E_DECODE);
      cyc("rt_ex",   0, 6'b000000, 0, 1, E_RTEX);
      cyc("rt_wb",   0, 6'b000000, 0, 1, E_RTWB);

      cyc("addi_f",  0, 6'b001000, 0, 1, E_FETCH1);
      cyc("addi_d",  0, 6'b001000, 0, 1, E_DECODE);
      cyc("addi_ex", 0, 6'b001000, 0, 1, E_ADDIEX);
      cyc("addi_wb", 0, 6'b001000, 0, 1, E_ADDIWB);

      cyc("j_f",     0, 6'b000010, 0, 1, E_FETCH1);
      cyc("j_d",     0, 6'b000010, 0, 1, E_DECODE);
      cyc("j_ex",    0, 6'b000010, 0, 1, E_JEX);

      cyc("lui_f",   0, 6'b001111, 0, 1, E_FETCH1);
      cyc("lui_d",   0, 6'b001111, 0, 1, E_DECODE);
      cyc("lui_wb",  0, 6'b001111, 0, 1, E_LUIWB);

      cyc("bad_f",   0, 6'b111111, 0, 1, E_FETCH1);
      cyc("bad_d",   0, 6'b111111, 0, 1, E_BAD);
      cyc("bad_ret", 0, 6'b111111, 0, 1, E_FETCH1);
      cyc("bad_d2",  0, 6'b111111, 0, 0, E_BAD);
      cyc("bad_ret2",0, 6'b111111, 0, 0, E_FETCH0);

      cyc("sw_f",    0, 6'b101011, 0, 1, E_FETCH1);
      cyc("sw_d",    0, 6'b101011, 0, 1, E_DECODE);
      cyc("sw_ma",   0, 6'b101011, 0, 1, E_MEMADR);
      cyc("sw_mw0",  0, 6'b101011, 0, 0, E_MEMWR);
      cyc("sw_rst",  1, 6'b101011, 0, 0, E_RST);
      cyc("sw_ret",  0, 6'b101011, 0, 1, E_FETCH1);

      cyc("sw2_d",   0, 6'b101011, 0, 1, E_DECODE);
      cyc("sw2_ma",  0, 6'b101011, 0, 1, E_MEMADR);
      cyc("sw2_mw",  0, 6'b101011, 0, 1, E_MEMWR);
      cyc("sw2_ret", 0, 6'b101011, 0, 1, E_FETCH1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
